// File: rtl/dual_issue_buffer.sv
// Fetch-to-decode instruction queue: up to two pushes per cycle, exposes the two
// oldest entries as issue slots A/B, retires one or two per decode's pairing decision.
module dual_issue_buffer #(
   parameter int DEPTH = 8,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          flush,
   input  logic          in_valid_a,
   input  logic [31:0]   in_instr_a,
   input  logic [31:0]   in_pcplus4_a,
   input  logic          in_valid_b,
   input  logic [31:0]   in_instr_b,
   input  logic [31:0]   in_pcplus4_b,
   output logic          in_ready,
   output logic          out_valid_a,
   output logic [31:0]   out_instr_a,
   output logic [31:0]   out_pcplus4_a,
   output logic          out_valid_b,
   output logic [31:0]   out_instr_b,
   output logic [31:0]   out_pcplus4_b,
   input  logic          pop_a,
   input  logic          pop_b,
   output logic [AW:0]   count
);

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pcplus4;
   } entry_t;

   localparam logic [AW:0] DEPTH_N = (AW+1)'(DEPTH);
   localparam logic [AW:0] TWO     = (AW+1)'(2);

   entry_t        mem [DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr, rd_ptr_b, wr_ptr_b;
   logic          push_a, push_b, pop_one, pop_two;
   logic [1:0]    n_push, n_pop;
   entry_t        slot_a, slot_b;

   // Readiness looks only at registered occupancy, so fetch never sees a pop-dependent path.
   assign in_ready    = (DEPTH_N - count) >= TWO;
   assign out_valid_a = (count != '0);
   assign out_valid_b = (count >= TWO);

   assign rd_ptr_b = rd_ptr + 1'b1;
   assign wr_ptr_b = wr_ptr + 1'b1;

   assign slot_a = out_valid_a ? mem[rd_ptr]   : '0;
   assign slot_b = out_valid_b ? mem[rd_ptr_b] : '0;

   assign out_instr_a   = slot_a.instr;
   assign out_pcplus4_a = slot_a.pcplus4;
   assign out_instr_b   = slot_b.instr;
   assign out_pcplus4_b = slot_b.pcplus4;

   assign push_a  = in_ready && in_valid_a;
   assign push_b  = push_a && in_valid_b;
   assign pop_one = pop_a && out_valid_a;
   assign pop_two = pop_one && pop_b && out_valid_b;

   assign n_push = {push_b, push_a && !push_b};
   assign n_pop  = {pop_two, pop_one && !pop_two};

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         rd_ptr <= rd_ptr + AW'(n_pop);
         wr_ptr <= wr_ptr + AW'(n_push);
         count  <= count + (AW+1)'(n_push) - (AW+1)'(n_pop);
      end
   end

   // Payload storage is never cleared; validity comes from count alone.
   always_ff @(posedge clk) begin
      if (reset_n && !flush) begin
         if (push_a) mem[wr_ptr]   <= '{instr: in_instr_a, pcplus4: in_pcplus4_a};
         if (push_b) mem[wr_ptr_b] <= '{instr: in_instr_b, pcplus4: in_pcplus4_b};
      end
   end

endmodule
